floating_divide: RTL and testbench

Sequential IEEE-754 single-precision divider, the inverse companion of the floating multiplier in the arithmetic datapath. Accepts a dividend `a` and divisor `b` on a start pulse, runs a restoring mantissa division one quotient bit per clock, then normalises, rounds and packs the result into `value` with a one-cycle `done` pulse. Latency is fixed for every operand class, so scheduling logic can count cycles.

---
 rtl/floating_divide.sv | 170 +++++++++++++++++
 tb/tb_floating_divide.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/floating_divide.sv
// floating_divide: sequential binary32 divider, one restoring quotient bit per clock.
// Latency is 27 cycles from the accepted start to done for every operand class.
// Build option: define FLOATING_DIVIDE_RNE_EN for round-to-nearest-even;
// leave it undefined for round toward zero (truncate).
//
// state | meaning
// IDLE  | waiting for start, done deasserted, busy drops here
// DIV   | 26 restoring iterations, one quotient bit per cycle
// NORM  | normalise, round, pack or apply special result, pulse done
`timescale 1ns/1ps

module floating_divide (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] value,
    output logic        done,
    output logic        busy,
    output logic [31:0] debug
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DIV  = 3'd1,
        NORM = 3'd2
    } state_t;

    localparam logic [1:0] SP_NONE = 2'd0;
    localparam logic [1:0] SP_NAN  = 2'd1;
    localparam logic [1:0] SP_INF  = 2'd2;
    localparam logic [1:0] SP_ZERO = 2'd3;

    state_t      state;
    logic [4:0]  iter;
    logic        sign;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [25:0] r;
    logic [25:0] q;
    logic [23:0] mb;
    logic [1:0]  spec;

    logic        a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
    logic [1:0]  spec_in;
    logic        r_ge;
    logic [25:0] r_sub;

    logic signed [9:0] exp_base;
    logic signed [9:0] exp_r;
    logic [23:0] mant;
    logic [24:0] mant_r;
    logic [22:0] frac;
    logic        inc;
    logic [31:0] result;
`ifdef FLOATING_DIVIDE_RNE_EN
    logic        guard;
    logic        sticky;
`endif

    assign debug = {24'b0, state, iter};

    // Classify the incoming operands; zero exponent counts as zero (no denormals).
    always_comb begin
        a_zero  = (a[30:23] == 8'h00);
        b_zero  = (b[30:23] == 8'h00);
        a_nan   = (a[30:23] == 8'hff) &&  (|a[22:0]);
        b_nan   = (b[30:23] == 8'hff) &&  (|b[22:0]);
        a_inf   = (a[30:23] == 8'hff) && !(|a[22:0]);
        b_inf   = (b[30:23] == 8'hff) && !(|b[22:0]);
        spec_in = SP_NONE;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            spec_in = SP_NAN;
        else if (a_inf || b_zero)
            spec_in = SP_INF;
        else if (a_zero || b_inf)
            spec_in = SP_ZERO;
    end

    // One restoring step: trial subtract of the divisor from the partial remainder.
    always_comb begin
        r_ge  = (r >= {2'b00, mb});
        r_sub = r_ge ? (r - {2'b00, mb}) : r;
    end

    // Normalise the quotient, round, and clamp to inf / signed zero.
    always_comb begin
        exp_base = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        if (!q[25])
            exp_base = exp_base - 10'sd1;
        mant = q[25] ? q[25:2] : q[24:1];
`ifdef FLOATING_DIVIDE_RNE_EN
        guard  = q[25] ? q[1] : q[0];
        sticky = (q[25] & q[0]) | (|r);
        inc    = guard & (sticky | mant[0]);
`else
        inc    = 1'b0;
`endif
        mant_r = {1'b0, mant} + {24'b0, inc};
        // A carry out leaves mant_r = 1.000..., so the shifted field is all zeros.
        exp_r  = mant_r[24] ? (exp_base + 10'sd1) : exp_base;
        frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        if (exp_r >= 10'sd255)
            result = {sign, 8'hff, 23'd0};
        else if (exp_r <= 10'sd0)
            result = {sign, 31'd0};
        else
            result = {sign, exp_r[7:0], frac};
        case (spec)
            SP_NAN:  result = 32'h7fc00000;
            SP_INF:  result = {sign, 8'hff, 23'd0};
            SP_ZERO: result = {sign, 31'd0};
            default: ;
        endcase
    end

    // Control FSM and datapath registers; outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            iter  <= 5'd0;
            sign  <= 1'b0;
            ea    <= 8'd0;
            eb    <= 8'd0;
            r     <= 26'd0;
            q     <= 26'd0;
            mb    <= 24'd0;
            spec  <= SP_NONE;
            value <= 32'd0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sign  <= a[31] ^ b[31];
                        ea    <= a[30:23];
                        eb    <= b[30:23];
                        r     <= a_zero ? 26'd0 : {3'b001, a[22:0]};
                        mb    <= b_zero ? 24'd0 : {1'b1, b[22:0]};
                        q     <= 26'd0;
                        iter  <= 5'd0;
                        spec  <= spec_in;
                        busy  <= 1'b1;
                        state <= DIV;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                DIV: begin
                    q    <= {q[24:0], r_ge};
                    r    <= r_sub << 1;
                    iter <= iter + 5'd1;
                    if (iter == 5'd25)
                        state <= NORM;
                end
                NORM: begin
                    value <= result;
                    done  <= 1'b1;
                    iter  <= 5'd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_floating_divide.sv
// tb_floating_divide: directed vectors into a scoreboard queue; a negedge monitor
// pops and checks value and latency whenever done is seen.
`timescale 1ns/1ps

module tb_floating_divide;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic [31:0] value;
    logic        done;
    logic        busy;
    logic [31:0] debug;

    floating_divide dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .value (value),
        .done  (done),
        .busy  (busy),
        .debug (debug)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] v;
        int          c;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef FLOATING_DIVIDE_RNE_EN
    localparam logic [31:0] THIRD = 32'h3eaaaaab;
`else
    localparam logic [31:0] THIRD = 32'h3eaaaaaa;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    // Monitor: every done pops one expectation; a done with nothing queued is an error.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got value %h, expected no done", value);
            end else begin
                mon_e = sbq.pop_front();
                chk("value", value, mon_e.v);
                chk("latency_cycle", cyc, mon_e.c);
            end
        end
    end

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [31:0] ev, input bit noisy);
        int  nbusy;
        bit  seen;
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        sbq.push_back('{v: ev, c: cyc + 27});
        nbusy = 0;
        seen  = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (noisy && (k == 5 || k == 20)) begin
                start = 1'b1;
                a = 32'h3f800000;
                b = 32'h40400000;
            end else begin
                start = 1'b0;
                a = 32'd0;
                b = 32'd0;
            end
            if (noisy && k <= 25)
                chk("debug_iter", debug, {24'b0, 3'd1, 5'(k)});
            if (busy) nbusy++;
            if (done) seen = 1'b1;
            if (!busy) break;
        end
        chk("busy_cycles", 32'(nbusy), 32'd28);
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done, expected one for %h / %h", ta, tb_v);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        int found;
        repeat (2) @(negedge clk);
        chk("reset_value", value, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_debug", debug, 32'd0);
        reset = 1'b0;

        do_op(32'h447a0000, 32'hc1200000, 32'hc2c80000, 1'b0);
        do_op(32'h3f800000, 32'h40400000, THIRD,        1'b0);
        do_op(32'h3f800000, 32'h00000000, 32'h7f800000, 1'b0);
        do_op(32'h00000000, 32'h00000000, 32'h7fc00000, 1'b0);
        do_op(32'h80000000, 32'h40000000, 32'h80000000, 1'b0);
        do_op(32'h7f800000, 32'h7f800000, 32'h7fc00000, 1'b0);
        do_op(32'h7f7fffff, 32'h3f000000, 32'h7f800000, 1'b0);
        do_op(32'h00800000, 32'h7f000000, 32'h00000000, 1'b0);
        do_op(32'h7fc00001, 32'h3f800000, 32'h7fc00000, 1'b0);
        do_op(32'hff800000, 32'h40000000, 32'hff800000, 1'b0);
        do_op(32'h40000000, 32'hff800000, 32'h80000000, 1'b0);
        do_op(32'h3f800000, 32'h3f800000, 32'h3f800000, 1'b0);
        do_op(32'h40c00000, 32'h40000000, 32'h40400000, 1'b1);

        // Abort mid-division: outputs clear at once and no done follows.
        @(negedge clk);
        a = 32'h447a0000;
        b = 32'hc1200000;
        start = 1'b1;
        @(posedge clk);
        #1;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (debug[4:0] == 5'd10) begin
                found = 1;
                break;
            end
        end
        chk("iter10_reached", 32'(found), 32'd1);
        reset = 1'b1;
        sbq.delete();
        #1;
        chk("abort_value", value, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_debug", debug, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_abort_busy", {31'd0, busy}, 32'd0);

        do_op(32'h447a0000, 32'hc1200000, 32'hc2c80000, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
